// File: rtl/am_lock_rx.sv
// Per-lane 40GBASE-R alignment-marker lock: finds the periodic AM, identifies the PCS lane,
// tracks lock/loss and forwards blocks with one register stage, flagging marker positions.
module am_lock_rx #(
  parameter int DATA_W    = 64,
  parameter int HEAD_W    = 2,
  parameter int AM_PERIOD = 16384,
  parameter int INVLD_MAX = 4
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              block_lock_i,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o,
  output logic              am_v_o,
  output logic              am_lock_o,
  output logic [1:0]        lane_id_o
);

  localparam int CNT_W = $clog2(AM_PERIOD);
  localparam int INV_W = $clog2(INVLD_MAX + 1);

  typedef enum logic [1:0] {FIND, COUNT_1, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [INV_W-1:0]  invld_q, invld_d, invld_inc;
  logic [1:0]        cand_q, cand_d;
  logic [1:0]        lane_q, lane_d;
  logic              lock_q, lock_d;
  logic              am_v_q, am_v_d;
  logic              valid_q;
  logic [HEAD_W-1:0] head_q;
  logic [DATA_W-1:0] data_q;

  logic              match_v;
  logic [1:0]        match_id;
  logic              slot;

  // Marker bytes {M2,M1,M0} of each PCS lane, byte 0 in the low bits.
  function automatic logic [23:0] am_pattern(input logic [1:0] id);
    logic [23:0] pat;
    case (id)
      2'd0:    pat = 24'h47_76_90;
      2'd1:    pat = 24'hE6_C4_F0;
      2'd2:    pat = 24'h9B_65_C5;
      default: pat = 24'h3D_79_A2;
    endcase
    return pat;
  endfunction

  // Bytes 3 and 7 carry BIP and are deliberately left out of the match.
  always_comb begin
    match_v  = 1'b0;
    match_id = 2'd0;
    if (valid_i && head_i == HEAD_W'(2'b01)) begin
      for (int l = 0; l < 4; l++) begin
        if (data_i[23:0] == am_pattern(2'(l)) && data_i[55:32] == ~am_pattern(2'(l))) begin
          match_v  = 1'b1;
          match_id = 2'(l);
        end
      end
    end
  end

  assign slot      = valid_i && (cnt_q == CNT_W'(AM_PERIOD - 1));
  assign invld_inc = invld_q + INV_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    invld_d = invld_q;
    cand_d  = cand_q;
    lane_d  = lane_q;
    lock_d  = lock_q;
    am_v_d  = 1'b0;
    if (!block_lock_i) begin
      state_d = FIND;
      cnt_d   = '0;
      invld_d = '0;
      lock_d  = 1'b0;
    end else if (valid_i) begin
      cnt_d = slot ? '0 : cnt_q + CNT_W'(1);
      case (state_q)
        FIND: begin
          if (match_v) begin
            cand_d  = match_id;
            cnt_d   = '0;
            state_d = COUNT_1;
          end
        end
        COUNT_1: begin
          if (slot) begin
            if (match_v && match_id == cand_q) begin
              state_d = LOCKED;
              lock_d  = 1'b1;
              lane_d  = cand_q;
              invld_d = '0;
              am_v_d  = 1'b1;
            end else if (match_v) begin
              cand_d = match_id;
              cnt_d  = '0;
            end else begin
              state_d = FIND;
            end
          end
        end
        LOCKED: begin
          if (slot) begin
            if (match_v && match_id == lane_q) begin
              invld_d = '0;
              am_v_d  = 1'b1;
            end else if (invld_inc == INV_W'(INVLD_MAX)) begin
              state_d = FIND;
              lock_d  = 1'b0;
              invld_d = '0;
            end else begin
              // A bad marker still sits in a marker slot, so deskew keeps seeing it.
              invld_d = invld_inc;
              am_v_d  = 1'b1;
            end
          end
        end
        default: state_d = FIND;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= FIND;
      cnt_q   <= '0;
      invld_q <= '0;
      cand_q  <= '0;
      lane_q  <= '0;
      lock_q  <= 1'b0;
      am_v_q  <= 1'b0;
      valid_q <= 1'b0;
      head_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      invld_q <= invld_d;
      cand_q  <= cand_d;
      lane_q  <= lane_d;
      lock_q  <= lock_d;
      am_v_q  <= am_v_d;
      valid_q <= valid_i;
      head_q  <= head_i;
      data_q  <= data_i;
    end
  end

  assign valid_o   = valid_q;
  assign head_o    = head_q;
  assign data_o    = data_q;
  assign am_v_o    = am_v_q;
  assign am_lock_o = lock_q;
  assign lane_id_o = lane_q;

endmodule

// File: tb/tb_am_lock_rx.sv
// Bench for am_lock_rx with a 16-block marker period: fixed vector table, directed
// multi-cycle sequences and a randomized stream checked against a block-index model.
module tb_am_lock_rx;

  localparam int P   = 16;
  localparam int INV = 4;
  localparam logic [63:0] IDLE = 64'h0000_0000_0000_001E;

  logic        clk = 1'b0;
  logic        nreset, block_lock_i, valid_i;
  logic [1:0]  head_i;
  logic [63:0] data_i;
  logic        valid_o, am_v_o, am_lock_o;
  logic [1:0]  head_o, lane_id_o;
  logic [63:0] data_o;

  am_lock_rx #(.DATA_W(64), .HEAD_W(2), .AM_PERIOD(P), .INVLD_MAX(INV)) dut (
    .clk(clk), .nreset(nreset), .block_lock_i(block_lock_i), .valid_i(valid_i),
    .head_i(head_i), .data_i(data_i), .valid_o(valid_o), .head_o(head_o), .data_o(data_o),
    .am_v_o(am_v_o), .am_lock_o(am_lock_o), .lane_id_o(lane_id_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] mk [4][3];

  typedef struct {
    logic        nrst;
    logic        v;
    logic [1:0]  h;
    logic [63:0] d;
    logic        e_amv;
    logic        e_lock;
    logic [1:0]  e_lane;
  } vec_t;
  vec_t tbl[$];

  // Reference model: absolute valid-block index, anchored on the candidate/locked marker.
  bit          m_locked, m_cand_v;
  int          m_cand, m_lane, m_bad;
  longint      m_vcnt, m_anchor;
  logic        e_valid, e_amv, e_lock;
  logic [1:0]  e_head, e_lane;
  logic [63:0] e_data;

  function automatic logic [63:0] am_word(input int l, input logic [7:0] b3, input logic [7:0] b7);
    return {b7, ~mk[l][2], ~mk[l][1], ~mk[l][0], b3, mk[l][2], mk[l][1], mk[l][0]};
  endfunction

  function automatic int am_lane(input logic [1:0] h, input logic [63:0] d);
    if (h != 2'b01) return -1;
    for (int l = 0; l < 4; l++) begin
      bit ok;
      ok = 1'b1;
      for (int b = 0; b < 3; b++)
        if (d[8*b +: 8] != mk[l][b] || d[8*(b+4) +: 8] != ~mk[l][b]) ok = 1'b0;
      if (ok) return l;
    end
    return -1;
  endfunction

  task automatic model_update(input logic r, input logic v, input logic bl,
                              input logic [1:0] h, input logic [63:0] d);
    int     m;
    longint pos;
    bit     slot;
    if (!r) begin
      m_locked = 0; m_cand_v = 0; m_cand = 0; m_lane = 0; m_bad = 0;
      m_vcnt = 0; m_anchor = 0;
      e_valid = 0; e_head = 0; e_data = 0; e_amv = 0; e_lock = 0; e_lane = 0;
      return;
    end
    e_valid = v; e_head = h; e_data = d; e_amv = 0;
    if (!bl) begin
      m_locked = 0; m_cand_v = 0; m_bad = 0;
    end else if (v) begin
      m = am_lane(h, d);
      m_vcnt++;
      pos  = m_vcnt - m_anchor;
      slot = (m_locked || m_cand_v) && pos > 0 && (pos % P) == 0;
      if (!m_locked && !m_cand_v) begin
        if (m >= 0) begin m_cand_v = 1; m_cand = m; m_anchor = m_vcnt; end
      end else if (m_cand_v) begin
        if (slot) begin
          if (m == m_cand) begin
            m_locked = 1; m_cand_v = 0; m_lane = m_cand; m_bad = 0; e_amv = 1;
          end else if (m >= 0) begin
            m_cand = m; m_anchor = m_vcnt;
          end else begin
            m_cand_v = 0;
          end
        end
      end else if (slot) begin
        if (m == m_lane) begin
          m_bad = 0; e_amv = 1;
        end else begin
          m_bad++;
          if (m_bad == INV) begin m_locked = 0; m_bad = 0; end
          else e_amv = 1;
        end
      end
    end
    e_lock = m_locked;
    e_lane = m_lane[1:0];
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic bl, input logic [1:0] h,
                      input logic [63:0] d, input string tag);
    nreset = r; valid_i = v; block_lock_i = bl; head_i = h; data_i = d;
    model_update(r, v, bl, h, d);
    @(posedge clk); #1;
    n_vec++;
    if ({valid_o, head_o, data_o, am_v_o, am_lock_o, lane_id_o} !==
        {e_valid, e_head, e_data, e_amv, e_lock, e_lane}) begin
      n_err++;
      $display("FAIL %s: got v=%0b h=%0b d=%h amv=%0b lock=%0b lane=%0d expected v=%0b h=%0b d=%h amv=%0b lock=%0b lane=%0d",
               tag, valid_o, head_o, data_o, am_v_o, am_lock_o, lane_id_o,
               e_valid, e_head, e_data, e_amv, e_lock, e_lane);
    end
  endtask

  task automatic send(input logic [63:0] d, input string tag);
    step(1'b1, 1'b1, 1'b1, 2'b01, d, tag);
  endtask

  task automatic idles(input int n, input string tag);
    for (int i = 0; i < n; i++) send(IDLE, tag);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1, 2'b00, 64'h0, "reset");
    step(1'b0, 1'b0, 1'b1, 2'b00, 64'h0, "reset");
  endtask

  function automatic void add(input logic nrst, input logic [1:0] h, input logic [63:0] d,
                              input logic amv, input logic lock, input logic [1:0] lane);
    vec_t r;
    r = '{nrst: nrst, v: nrst, h: h, d: d, e_amv: amv, e_lock: lock, e_lane: lane};
    tbl.push_back(r);
  endfunction

  initial begin
    logic [63:0] am0_noinv, d;
    logic [1:0]  h;
    logic        r, v, bl;
    int          g, fav, x;

    mk[0] = '{8'h90, 8'h76, 8'h47};
    mk[1] = '{8'hF0, 8'hC4, 8'hE6};
    mk[2] = '{8'hC5, 8'h65, 8'h9B};
    mk[3] = '{8'hA2, 8'h79, 8'h3D};
    nreset = 1'b0; block_lock_i = 1'b1; valid_i = 1'b0; head_i = 2'b00; data_i = 64'h0;

    // Table: reset, lane-2 lock, non-inverted AM, wrong sync header.
    add(0, 2'b00, 64'h0, 0, 0, 0);
    add(0, 2'b00, 64'h0, 0, 0, 0);
    for (int i = 0; i <= 32; i++)
      add(1, 2'b01, (i % 16 == 0) ? am_word(2, 8'h11, 8'h22) : IDLE,
          (i == 16 || i == 32), (i >= 16), (i >= 16) ? 2'd2 : 2'd0);
    add(0, 2'b00, 64'h0, 0, 0, 0);
    am0_noinv = {8'h00, mk[0][2], mk[0][1], mk[0][0], 8'h00, mk[0][2], mk[0][1], mk[0][0]};
    for (int i = 0; i <= 32; i++)
      add(1, 2'b01, (i == 0) ? am0_noinv : (i % 16 == 0) ? am_word(0, 8'h00, 8'h00) : IDLE,
          (i == 32), (i >= 32), 2'd0);
    add(0, 2'b00, 64'h0, 0, 0, 0);
    for (int i = 0; i <= 32; i++)
      add(1, (i == 0) ? 2'b10 : 2'b01, (i % 16 == 0) ? am_word(3, 8'h5A, 8'hA5) : IDLE,
          (i == 32), (i >= 32), (i >= 32) ? 2'd3 : 2'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      nreset = tbl[i].nrst; valid_i = tbl[i].v; block_lock_i = 1'b1;
      head_i = tbl[i].h; data_i = tbl[i].d;
      @(posedge clk); #1;
      n_vec++;
      if (am_v_o !== tbl[i].e_amv || am_lock_o !== tbl[i].e_lock || lane_id_o !== tbl[i].e_lane ||
          valid_o !== tbl[i].v || data_o !== (tbl[i].nrst ? tbl[i].d : 64'h0)) begin
        n_err++;
        $display("FAIL table[%0d]: got amv=%0b lock=%0b lane=%0d v=%0b d=%h expected amv=%0b lock=%0b lane=%0d v=%0b d=%h",
                 i, am_v_o, am_lock_o, lane_id_o, valid_o, data_o,
                 tbl[i].e_amv, tbl[i].e_lock, tbl[i].e_lane, tbl[i].v,
                 tbl[i].nrst ? tbl[i].d : 64'h0);
      end
    end

    // Candidate replaced by a different lane at the slot.
    do_reset();
    send(am_word(1, 0, 0), "t2 am1");
    idles(15, "t2 idle");
    send(am_word(3, 0, 0), "t2 am3a");
    chk("t2 no lock at 16", am_lock_o, 0);
    idles(15, "t2 idle");
    send(am_word(3, 0, 0), "t2 am3b");
    chk("t2 lock at 32", am_lock_o, 1);
    chk("t2 lane", lane_id_o, 3);

    // Bad-marker counting while locked on lane 0.
    do_reset();
    send(am_word(0, 0, 0), "t3 am0");
    idles(15, "t3 idle");
    send(am_word(0, 0, 0), "t3 lock");
    chk("t3 locked", am_lock_o, 1);
    for (int s = 1; s <= 8; s++) begin
      idles(15, "t3 idle");
      d = am_word(0, 0, 0);
      if (s != 4) d = d ^ 64'h0000_0000_0000_FF00;
      send(d, "t3 slot");
      chk($sformatf("t3 lock slot%0d", s), am_lock_o, (s < 8));
      chk($sformatf("t3 amv slot%0d", s), am_v_o, (s < 8));
    end

    // Gaps in valid_i, extra mid-period AM ignored.
    do_reset();
    send(am_word(1, 0, 0), "t4 am1");
    for (int k = 1; k <= 16; k++) begin
      repeat ($urandom_range(0, 3)) step(1'b1, 1'b0, 1'b1, 2'($urandom), {$urandom, $urandom}, "t4 gap");
      send((k == 8 || k == 16) ? am_word(1, 0, 0) : IDLE, "t4 blk");
    end
    chk("t4 lock", am_lock_o, 1);
    chk("t4 lane", lane_id_o, 1);
    chk("t4 amv", am_v_o, 1);

    // Block-lock drop forces relock from FIND.
    step(1'b1, 1'b1, 1'b0, 2'b01, IDLE, "t5 drop");
    chk("t5 lock lost", am_lock_o, 0);
    chk("t5 lane kept", lane_id_o, 1);
    send(am_word(1, 0, 0), "t5 am a");
    chk("t5 no lock after 1 AM", am_lock_o, 0);
    idles(15, "t5 idle");
    send(am_word(1, 0, 0), "t5 am b");
    chk("t5 relock", am_lock_o, 1);

    // Randomized stream against the model.
    do_reset();
    g = 0;
    fav = $urandom_range(0, 3);
    for (int c = 0; c < 6000; c++) begin
      r  = ($urandom_range(0, 799) != 0);
      bl = ($urandom_range(0, 299) != 0);
      v  = ($urandom_range(0, 99) < 85);
      h  = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      d  = {$urandom, $urandom};
      if (v) begin
        g++;
        if (g % P == 0) begin
          x = $urandom_range(0, 9);
          h = 2'b01;
          if (x < 7)       d = am_word(fav, 8'($urandom), 8'($urandom));
          else if (x == 7) d = am_word($urandom_range(0, 3), 0, 0);
          else if (x == 8) d = am_word(fav, 0, 0) ^ (64'hFF << (8 * $urandom_range(4, 6)));
          else             d = IDLE;
        end else if ($urandom_range(0, 19) == 0) begin
          h = 2'b01;
          d = am_word($urandom_range(0, 3), 0, 0);
        end
      end
      if ($urandom_range(0, 499) == 0) fav = $urandom_range(0, 3);
      step(r, v, bl, h, d, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
